// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, vector
// defaults and the lowest-index priority encoder.
package intr_pkg;

    localparam int MAX_SRC = 32;
    localparam int ID_W    = 5;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WB = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_VECTOR  = 2'd3
    } intr_state_e;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
    } prio_t;

    // Scans from the top down so the last hit, the lowest set index, wins.
    function automatic prio_t prio_lowest(input logic [MAX_SRC-1:0] req);
        prio_t r;
        r.found = 1'b0;
        r.id    = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.found = 1'b1;
                r.id    = ID_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a
// rising-edge detector that emits a single-cycle pulse per request.
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt request side of the CP0 exception interface: latches request
// edges, arbitrates against mask/IE/in-service state and drives BK/NIE.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int          NUM_SRC     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE  = VEC_STRIDE_DEF
) (
    input  logic               in_clk,
    input  logic               in_RST,
    input  logic [NUM_SRC-1:0] in_irq,
    input  logic               in_IE,
    input  logic [NUM_SRC-1:0] in_INM,
    input  logic               in_eret,
    input  logic               in_wb_valid,
    input  logic [31:0]        in_WB_PC,
    input  logic               in_vec_ack,
    output logic               out_BK,
    output logic               out_NIE,
    output logic [31:0]        out_EPC_next,
    output logic               out_vec_valid,
    output logic [31:0]        out_vec_pc,
    output logic [NUM_SRC-1:0] out_pending,
    output logic [NUM_SRC-1:0] out_isr,
    output intr_state_e        dbg_state
);

    // Handshake: out_vec_valid rises the cycle after the single BK/NIE pulse and
    // holds out_vec_pc stable until in_vec_ack is sampled high; it then drops.

    intr_state_e        state_q, state_d;
    logic [ID_W-1:0]    win_id_q, win_id_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic [31:0]        epc_q, vec_q, vec_calc;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] isr_upto;
    logic [NUM_SRC-1:0] win_oh;
    logic [NUM_SRC-1:0] eret_oh;
    logic [MAX_SRC-1:0] elig_ext, isr_ext;
    prio_t              elig_pick, isr_pick;
    logic               is_flush;
    logic               win_still_eligible;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        intr_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk (in_clk),
            .rst (in_RST),
            .irq (in_irq[g]),
            .rise(rise[g])
        );
    end

    // A source may only preempt when nothing at its own or higher priority is in service.
    always_comb begin
        isr_upto = '0;
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i == 0) begin
                isr_upto[i] = isr_q[i];
            end else begin
                isr_upto[i] = isr_upto[i-1] | isr_q[i];
            end
            eligible[i] = pending_q[i] & ~in_INM[i] & ~isr_upto[i];
        end
    end

    always_comb begin
        elig_ext                = '0;
        isr_ext                 = '0;
        elig_ext[NUM_SRC-1:0]   = eligible;
        isr_ext[NUM_SRC-1:0]    = isr_q;
        elig_pick               = prio_lowest(elig_ext);
        isr_pick                = prio_lowest(isr_ext);
    end

    always_comb begin
        win_oh  = '0;
        eret_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            win_oh[i]  = (win_id_q == ID_W'(i));
            eret_oh[i] = in_eret & isr_pick.found & (isr_pick.id == ID_W'(i));
        end
    end

    assign is_flush           = (state_q == ST_FLUSH);
    assign win_still_eligible = |(eligible & win_oh);

    always_comb begin
        state_d  = state_q;
        win_id_d = win_id_q;
        case (state_q)
            ST_IDLE: begin
                if (in_IE && elig_pick.found) begin
                    win_id_d = elig_pick.id;
                    state_d  = ST_WAIT_WB;
                end
            end
            ST_WAIT_WB: begin
                if (!in_IE || !win_still_eligible) begin
                    state_d = ST_IDLE;
                end else if (in_wb_valid) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                if (in_vec_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear before set: a fresh edge on the winner during FLUSH keeps it pending,
    // and an eret in FLUSH retires the old handler before the new one is marked.
    always_comb begin
        pending_d = (pending_q & ~(is_flush ? win_oh : '0)) | rise;
        isr_d     = (isr_q & ~eret_oh) | (is_flush ? win_oh : '0);
    end

    assign vec_calc = VEC_BASE + (VEC_STRIDE * {{(32-ID_W){1'b0}}, win_id_q});

    always_ff @(posedge in_clk or posedge in_RST) begin
        if (in_RST) begin
            state_q   <= ST_IDLE;
            win_id_q  <= '0;
            pending_q <= '0;
            isr_q     <= '0;
            epc_q     <= '0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_id_q  <= win_id_d;
            pending_q <= pending_d;
            isr_q     <= isr_d;
            if (is_flush) begin
                epc_q <= in_WB_PC;
                vec_q <= vec_calc;
            end
        end
    end

    assign out_BK        = is_flush;
    assign out_NIE       = is_flush;
    assign out_EPC_next  = epc_q;
    assign out_vec_valid = (state_q == ST_VECTOR);
    assign out_vec_pc    = vec_q;
    assign out_pending   = pending_q;
    assign out_isr       = isr_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a behavioural model checked every cycle, a
// vector scoreboard and hand-computed literal expectations for each scenario.
module tb_intr_ctrl;
    import intr_pkg::*;

    localparam int NS = 4;
    localparam int SY = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NS-1:0] irq      = '0;
    logic          ie       = 1'b0;
    logic [NS-1:0] inm      = '0;
    logic          eret     = 1'b0;
    logic          wb_valid = 1'b0;
    logic [31:0]   wb_pc    = '0;
    logic          vec_ack  = 1'b0;

    logic          bk, nie, vec_valid;
    logic [31:0]   epc_next, vec_pc;
    logic [NS-1:0] pending, isr;
    intr_state_e   dbg_state;

    intr_ctrl #(
        .NUM_SRC    (NS),
        .SYNC_STAGES(SY),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0010)
    ) dut (
        .in_clk       (clk),
        .in_RST       (rst),
        .in_irq       (irq),
        .in_IE        (ie),
        .in_INM       (inm),
        .in_eret      (eret),
        .in_wb_valid  (wb_valid),
        .in_WB_PC     (wb_pc),
        .in_vec_ack   (vec_ack),
        .out_BK       (bk),
        .out_NIE      (nie),
        .out_EPC_next (epc_next),
        .out_vec_valid(vec_valid),
        .out_vec_pc   (vec_pc),
        .out_pending  (pending),
        .out_isr      (isr),
        .dbg_state    (dbg_state)
    );

    int total    = 0;
    int bad      = 0;
    int bk_count = 0;
    logic [31:0] exp_q[$];

    // ---------------- behavioural model ----------------
    // phase: 0 nothing chosen, 1 waiting for a WB instruction, 2 break cycle, 3 vector offered
    int            m_phase = 0;
    int            m_id    = 0;
    logic [NS-1:0] m_pend  = '0;
    logic [NS-1:0] m_isr   = '0;
    logic [31:0]   m_epc   = '0;
    logic [31:0]   m_vec   = '0;
    logic [NS-1:0] hist [SY+2];
    logic [NS-1:0] m_rise, m_elig, n_pend, n_isr;
    logic          m_done;

    initial begin
        for (int k = 0; k < SY + 2; k++) hist[k] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0;
                m_id    = 0;
                m_pend  = '0;
                m_isr   = '0;
                m_epc   = '0;
                m_vec   = '0;
                for (int k = 0; k < SY + 2; k++) hist[k] = '0;
                exp_q.delete();
            end else begin
                for (int k = SY + 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = irq;
                m_rise  = hist[SY] & ~hist[SY+1];
                for (int i = 0; i < NS; i++) begin
                    m_elig[i] = m_pend[i] && !inm[i] && ((int'(m_isr) % (1 << (i + 1))) == 0);
                end
                n_isr = m_isr;
                if (eret) begin
                    m_done = 1'b0;
                    for (int i = 0; i < NS; i++) begin
                        if (!m_done && n_isr[i]) begin
                            n_isr[i] = 1'b0;
                            m_done   = 1'b1;
                        end
                    end
                end
                n_pend = m_pend;
                if (m_phase == 2) begin
                    n_isr[m_id]  = 1'b1;
                    n_pend[m_id] = 1'b0;
                    m_epc = wb_pc;
                    m_vec = 32'h100 + 32'(m_id) * 32'h10;
                    exp_q.push_back(m_vec);
                end
                n_pend = n_pend | m_rise;
                case (m_phase)
                    0: begin
                        if (ie && m_elig != '0) begin
                            for (int i = NS - 1; i >= 0; i--) if (m_elig[i]) m_id = i;
                            m_phase = 1;
                        end
                    end
                    1: begin
                        if (!ie || !m_elig[m_id]) m_phase = 0;
                        else if (wb_valid) m_phase = 2;
                    end
                    2: m_phase = 3;
                    default: if (vec_ack) m_phase = 0;
                endcase
                m_pend = n_pend;
                m_isr  = n_isr;
            end
        end
    end

    // ---------------- compare process / scoreboard ----------------
    logic prev_vv = 1'b0;
    logic [31:0] sb_want;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                total++;
                if ({bk, nie, vec_valid, pending, isr, epc_next, vec_pc} !==
                    {m_phase == 2, m_phase == 2, m_phase == 3, m_pend, m_isr, m_epc, m_vec}) begin
                    bad++;
                    $display("FAIL cycle_model t=%0t got bk=%b nie=%b vv=%b pend=%b isr=%b epc=%h vec=%h st=%0d want bk=%b vv=%b pend=%b isr=%b epc=%h vec=%h",
                             $time, bk, nie, vec_valid, pending, isr, epc_next, vec_pc, int'(dbg_state),
                             m_phase == 2, m_phase == 3, m_pend, m_isr, m_epc, m_vec);
                end
                if (bk === 1'b1) bk_count++;
                if (vec_valid === 1'b1 && !prev_vv) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_vector t=%0t got vec=%h want none", $time, vec_pc);
                    end else begin
                        sb_want = exp_q.pop_front();
                        if (vec_pc !== sb_want) begin
                            bad++;
                            $display("FAIL sb_vector t=%0t got vec=%h want %h", $time, vec_pc, sb_want);
                        end
                    end
                end
                prev_vv = vec_valid;
            end else begin
                prev_vv = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_vector();
        vec_ack = 1'b1;
        irq     = '0;
        cyc(1);
        vec_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        cyc(3);
        chk("rst_bk", 32'(bk), 32'h0);
        chk("rst_vv", 32'(vec_valid), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_isr", 32'(isr), 32'h0);
        chk("rst_vec", vec_pc, 32'h0);
        chk("rst_epc", epc_next, 32'h0);
        rst      = 1'b0;
        ie       = 1'b1;
        inm      = '0;
        wb_valid = 1'b1;
        wb_pc    = 32'h40;
        cyc(2);

        // single request on source 2
        irq = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            cyc(1);
            chk("s2_bk_timing", 32'(bk), (c == 5) ? 32'h1 : 32'h0);
            if (c == 3) chk("s2_pend_vis", 32'(pending), 32'h4);
            if (c == 5) chk("s2_nie", 32'(nie), 32'h1);
        end
        chk("s2_vv", 32'(vec_valid), 32'h1);
        chk("s2_vec", vec_pc, 32'h120);
        chk("s2_epc", epc_next, 32'h40);
        chk("s2_isr", 32'(isr), 32'h4);
        chk("s2_pend_clr", 32'(pending), 32'h0);
        ack_vector();
        chk("s2_vv_drop", 32'(vec_valid), 32'h0);
        cyc(4);

        // priority and nesting: sources 3 and 1 together under isr=0100
        irq = 4'b1010;
        cyc(5);
        chk("s3_bk", 32'(bk), 32'h1);
        cyc(1);
        chk("s3_vec", vec_pc, 32'h110);
        chk("s3_isr", 32'(isr), 32'h6);
        chk("s3_pend", 32'(pending), 32'h8);
        ack_vector();
        cyc(3);
        chk("s3_blocked", 32'(pending), 32'h8);
        pulse_eret();
        cyc(3);
        chk("s3_eret1_isr", 32'(isr), 32'h4);
        chk("s3_eret1_pend", 32'(pending), 32'h8);
        pulse_eret();
        cyc(3);
        chk("s3_src3_vv", 32'(vec_valid), 32'h1);
        chk("s3_src3_vec", vec_pc, 32'h130);
        chk("s3_src3_isr", 32'(isr), 32'h8);
        ack_vector();
        pulse_eret();
        cyc(2);

        // masking aborts a waiting interrupt
        wb_valid = 1'b0;
        irq      = 4'b0001;
        cyc(4);
        chk("s4_wait", 32'(dbg_state), 32'(ST_WAIT_WB));
        inm = 4'b0001;
        cyc(1);
        irq = '0;
        chk("s4_abort", 32'(dbg_state), 32'(ST_IDLE));
        for (int c = 0; c < 4; c++) begin
            cyc(1);
            chk("s4_no_bk", 32'(bk), 32'h0);
        end
        chk("s4_pend", 32'(pending), 32'h1);

        // eret coinciding with FLUSH of source 0 while source 1 is in service
        wb_valid = 1'b1;
        irq      = 4'b0010;
        cyc(5);
        chk("s5_bk1", 32'(bk), 32'h1);
        cyc(1);
        chk("s5_isr1", 32'(isr), 32'h2);
        ack_vector();
        inm   = '0;
        wb_pc = 32'h88;
        cyc(2);
        chk("s5_bk0", 32'(bk), 32'h1);
        eret = 1'b1;
        cyc(1);
        eret = 1'b0;
        chk("s5_isr", 32'(isr), 32'h1);
        chk("s5_vec", vec_pc, 32'h100);
        chk("s5_epc", epc_next, 32'h88);
        ack_vector();
        pulse_eret();
        cyc(2);

        // re-trigger of source 2 in its own FLUSH cycle
        wb_valid = 1'b0;
        irq      = 4'b0100;
        cyc(2);
        irq = '0;
        cyc(5);
        chk("s6_wait", 32'(dbg_state), 32'(ST_WAIT_WB));
        irq = 4'b0100;
        cyc(1);
        wb_valid = 1'b1;
        cyc(1);
        chk("s6_bk", 32'(bk), 32'h1);
        cyc(1);
        chk("s6_pend_kept", 32'(pending), 32'h4);
        chk("s6_isr", 32'(isr), 32'h4);
        ack_vector();
        pulse_eret();
        cyc(3);
        chk("s6_again_vv", 32'(vec_valid), 32'h1);
        chk("s6_again_pend", 32'(pending), 32'h0);

        // asynchronous reset in the middle of VECTOR
        #2;
        rst = 1'b1;
        #1;
        chk("s7_vv", 32'(vec_valid), 32'h0);
        chk("s7_pend", 32'(pending), 32'h0);
        chk("s7_isr", 32'(isr), 32'h0);
        chk("s7_vec", vec_pc, 32'h0);
        cyc(2);
        rst = 1'b0;
        cyc(3);
        chk("s7_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("s7_vv_after", 32'(vec_valid), 32'h0);

        chk("bk_pulses", 32'(bk_count), 32'd7);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
